hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: detects RAW/WAW hazards for the ID stage and drives
// stall/flush controls combinationally; counters freeze under mem_hold and keep draining on redirect.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int NSRC     = 3,
  parameter int CW       = 3,
  parameter int LAT_ALU  = 0,
  parameter int LAT_LOAD = 1,
  parameter int LAT_MUL  = 2,
  parameter int BR_EXTRA = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [NSRC*5-1:0] src_no,
  input  logic [NSRC-1:0]   src_used,
  input  logic              is_compare,
  input  logic [4:0]        dst_no,
  input  logic              dst_we,
  input  logic [1:0]        lat_class,
  input  logic              mem_hold,
  input  logic              redirect,
  output logic              id_we,
  output logic              pc_we,
  output logic              ex_flush,
  output logic              id_flush,
  output logic [NREG-1:0]   busy_vec,
  output logic [31:0]       stall_cnt
);

  localparam logic [5:0] NREG_W = 6'(NREG);

  logic [CW-1:0]   cnt_q [NREG];
  logic [CW-1:0]   cnt_d [NREG];
  logic [NREG-1:0] recent_q, recent_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;
  logic [CW-1:0]   lat_sel;
  logic            raw, waw, stall, hold, issue;

  function automatic logic tracked(input logic [4:0] r);
    return (r != 5'd0) && ({1'b0, r} < NREG_W);
  endfunction

  always_comb begin
    case (lat_class)
      2'd1:    lat_sel = CW'(LAT_LOAD);
      2'd2:    lat_sel = CW'(LAT_MUL);
      default: lat_sel = CW'(LAT_ALU);
    endcase
  end

  // A compare resolves in ID, so it also waits out the cycle right after its producer issued.
  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_used[i] && tracked(src_no[i*5 +: 5])) begin
        if (cnt_q[src_no[i*5 +: 5]] != '0) raw = 1'b1;
        if (is_compare && (BR_EXTRA != 0) && recent_q[src_no[i*5 +: 5]]) raw = 1'b1;
      end
    end
  end

  assign waw   = dst_we && tracked(dst_no) && (lat_sel < cnt_q[dst_no]);
  assign hold  = mem_hold & rst_n;
  assign stall = id_valid & ~redirect & (raw | waw);
  assign issue = id_valid & ~stall & ~redirect & ~hold;

  assign id_we     = ~stall & ~hold;
  assign pc_we     = ~stall & ~hold;
  assign ex_flush  = stall & ~hold;
  assign id_flush  = redirect;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_vec[r] = (r != 0) && (cnt_q[r] != '0);
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    recent_d    = recent_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
      end
      recent_d = '0;
      if (issue && dst_we && tracked(dst_no)) begin
        cnt_d[dst_no]    = lat_sel;
        recent_d[dst_no] = 1'b1;
      end
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end
    cnt_d[0]    = '0;
    recent_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      recent_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      recent_q    <= recent_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector table plus randomized run against a timestamp-based hazard model.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [14:0] src_no;
  logic [2:0]  src_used;
  logic        is_compare;
  logic [4:0]  dst_no;
  logic        dst_we;
  logic [1:0]  lat_class;
  logic        mem_hold;
  logic        redirect;
  logic        id_we, pc_we, ex_flush, id_flush;
  logic [31:0] busy_vec;
  logic [31:0] stall_cnt;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .src_no(src_no), .src_used(src_used),
    .is_compare(is_compare), .dst_no(dst_no), .dst_we(dst_we), .lat_class(lat_class),
    .mem_hold(mem_hold), .redirect(redirect), .id_we(id_we), .pc_we(pc_we),
    .ex_flush(ex_flush), .id_flush(id_flush), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id_we;
    logic        pc_we;
    logic        ex_flush;
    logic        id_flush;
    logic [31:0] busy;
    logic [31:0] sc;
  } obs_t;

  typedef struct {
    logic v; logic [4:0] s; logic [2:0] u; logic cmp;
    logic [4:0] d; logic we; logic [1:0] cls; logic hold; logic redir;
    logic e_we; logic e_xf; logic e_if; logic [31:0] e_busy; logic [31:0] e_sc;
  } row_t;

  row_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Model: t counts non-frozen cycles; a result is forwardable once t reaches avail[r].
  int          t;
  int          avail[32];
  int          iss[32];
  logic [31:0] sc_m;

  function automatic int lat_of(input logic [1:0] c);
    return (c == 2'd1) ? 1 : (c == 2'd2) ? 2 : 0;
  endfunction

  function automatic int remaining(input int r);
    return (avail[r] > t) ? avail[r] - t : 0;
  endfunction

  function automatic obs_t model_exp();
    obs_t o;
    logic raw, waw, st;
    raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      int s;
      s = int'(src_no[i*5 +: 5]);
      if (src_used[i] && s != 0) begin
        if (remaining(s) > 0) raw = 1'b1;
        if (is_compare && t == iss[s] + 1) raw = 1'b1;
      end
    end
    waw = dst_we && dst_no != 5'd0 && (lat_of(lat_class) < remaining(int'(dst_no)));
    st  = id_valid && !redirect && (raw || waw);
    o.id_we    = !st && !mem_hold;
    o.pc_we    = !st && !mem_hold;
    o.ex_flush = st && !mem_hold;
    o.id_flush = redirect;
    for (int r = 0; r < 32; r++) o.busy[r] = (r != 0) && (remaining(r) > 0);
    o.sc = sc_m;
    return o;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      avail[r] = 0;
      iss[r]   = -100;
    end
    t    = 0;
    sc_m = 32'd0;
  endtask

  task automatic model_step();
    obs_t o;
    o = model_exp();
    if (!mem_hold) begin
      if (o.ex_flush && sc_m != 32'hFFFF_FFFF) sc_m = sc_m + 32'd1;
      if (id_valid && !o.ex_flush && !redirect && dst_we && dst_no != 5'd0) begin
        avail[dst_no] = t + 1 + lat_of(lat_class);
        iss[dst_no]   = t;
      end
      t = t + 1;
    end
  endtask

  task automatic check(input string nm, input obs_t exp);
    obs_t got;
    got = {id_we, pc_we, ex_flush, id_flush, busy_vec, stall_cnt};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got we=%b pcwe=%b exfl=%b idfl=%b busy=%h sc=%0d, expected we=%b pcwe=%b exfl=%b idfl=%b busy=%h sc=%0d",
               nm, got.id_we, got.pc_we, got.ex_flush, got.id_flush, got.busy, got.sc,
               exp.id_we, exp.pc_we, exp.ex_flush, exp.id_flush, exp.busy, exp.sc);
    end
  endtask

  // Called at posedge+1 with inputs already driven; samples at the falling edge.
  task automatic run_cycle(input string nm, input logic use_model, input obs_t exp_in);
    #4;
    check(nm, use_model ? model_exp() : exp_in);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] s, input logic [2:0] u, input logic cmp,
                       input logic [4:0] d, input logic we, input logic [1:0] cls,
                       input logic hold, input logic redir);
    id_valid = v; src_no = {10'd0, s}; src_used = u; is_compare = cmp;
    dst_no = d; dst_we = we; lat_class = cls; mem_hold = hold; redirect = redir;
  endtask

  function automatic row_t mk(input logic v, input logic [4:0] s, input logic [2:0] u,
                              input logic cmp, input logic [4:0] d, input logic we,
                              input logic [1:0] cls, input logic hold, input logic redir,
                              input logic e_we, input logic e_xf, input logic e_if,
                              input logic [31:0] e_busy, input logic [31:0] e_sc);
    row_t r;
    r.v = v; r.s = s; r.u = u; r.cmp = cmp; r.d = d; r.we = we; r.cls = cls;
    r.hold = hold; r.redir = redir; r.e_we = e_we; r.e_xf = e_xf; r.e_if = e_if;
    r.e_busy = e_busy; r.e_sc = e_sc;
    return r;
  endfunction

  initial begin
    obs_t e;
    //            v  s  u  c  d  we cls h  rd   we xf if busy        sc
    tbl.push_back(mk(1, 0, 0, 0, 5, 1, 1, 0, 0,  1, 0, 0, 32'h0,      0)); // load r5
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 32'h20,     0)); // load-use stall
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 32'h0,      1));
    tbl.push_back(mk(1, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 0, 32'h0,      1)); // alu r7
    tbl.push_back(mk(1, 7, 1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 32'h0,      1)); // compare waits
    tbl.push_back(mk(1, 7, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 32'h0,      2));
    tbl.push_back(mk(1, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 0, 32'h0,      2)); // alu r7
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 32'h0,      2)); // non-compare no wait
    tbl.push_back(mk(1, 0, 0, 0, 3, 1, 2, 0, 0,  1, 0, 0, 32'h0,      2)); // mul r3
    tbl.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 0,  0, 1, 0, 32'h8,      2)); // waw alu r3
    tbl.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 0,  0, 1, 0, 32'h8,      3));
    tbl.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 0,  1, 0, 0, 32'h0,      4));
    tbl.push_back(mk(1, 0, 0, 0, 4, 1, 1, 0, 0,  1, 0, 0, 32'h0,      4)); // load r4
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 32'h10,   4)); // frozen
    tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 32'h10,     4));
    tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 32'h0,      5));
    tbl.push_back(mk(1, 0, 0, 0, 6, 1, 1, 0, 0,  1, 0, 0, 32'h0,      5)); // load r6
    tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 1,  1, 0, 1, 32'h40,     5)); // redirect beats raw
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 2, 0, 0,  1, 0, 0, 32'h0,      5)); // r0 src/dst
    tbl.push_back(mk(1, 0, 0, 0, 9, 1, 1, 0, 0,  1, 0, 0, 32'h0,      5)); // load r9
    tbl.push_back(mk(0, 9, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 32'h200,    5)); // invalid ID
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 32'h0,      5)); // r0 compare

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    model_reset();
    #1;
    check("reset_state", '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0});
    redirect = 1'b0;
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].u, tbl[i].cmp, tbl[i].d, tbl[i].we, tbl[i].cls,
            tbl[i].hold, tbl[i].redir);
      e = '{tbl[i].e_we, tbl[i].e_we, tbl[i].e_xf, tbl[i].e_if, tbl[i].e_busy, tbl[i].e_sc};
      run_cycle($sformatf("tbl[%0d]", i), 1'b0, e);
    end

    drive(1, 0, 0, 0, 3, 1, 2, 0, 0);
    run_cycle("mul_r3_issue", 1'b1, '0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("mul_r3_inflight", 1'b1, '0);
    #1 rst_n = 1'b0;
    #1 check("reset_mid_mul", '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0});
    model_reset();
    rst_n = 1'b1;
    drive(1, 3, 1, 1, 0, 0, 0, 0, 0);
    run_cycle("dep_after_reset", 1'b0, '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0});

    for (int k = 0; k < 3000; k++) begin
      id_valid   = ($urandom_range(3, 0) != 0);
      src_no     = {5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0))};
      src_used   = 3'($urandom_range(7, 0));
      is_compare = ($urandom_range(3, 0) == 0);
      dst_no     = 5'($urandom_range(7, 0));
      dst_we     = ($urandom_range(1, 0) == 1);
      lat_class  = 2'($urandom_range(3, 0));
      mem_hold   = ($urandom_range(7, 0) == 0);
      redirect   = ($urandom_range(7, 0) == 0);
      if ($urandom_range(199, 0) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
      end
      run_cycle("random", 1'b1, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
